aes_inv_key_schedule: RTL and testbench
=======================================

# aes_inv_key_schedule

Iterative AES-128 inverse key schedule for the decryption datapath. Takes the round-10 key (last encryption round key) and regenerates round keys 10, 9, …, 0 one per handshake, so the inverse cipher consumes keys in its natural order without storing all 1408 bits. It sits between the key source and the AES-128 inverse round datapath, and is the counterpart of the forward key expansion.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- start  in  1  load request; sampled only when busy=0
- last_key  in  [0:127]  round-10 key; word 0 = bits [0:31], MSB-first byte order
- busy  out  1  high from accepted start until the round-0 handshake completes
- rk_valid  out  1  round_key/round_idx are valid
- rk_ready  in  1  consumer accepts the current key
- round_key  out  [0:127]  current round key, same word/byte ordering as last_key
- round_idx  out  4  round number of round_key (10 down to 0)
- done  out  1  one-cycle pulse after the round-0 key is accepted

## Operation
- FSM states: IDLE, EMIT.
- IDLE: rk_valid=0. On start=1, register last_key into the key register, set round_idx=10, and go to EMIT.
- EMIT: rk_valid=1. On rk_valid&rk_ready:
  - idx>0: replace the key with its predecessor and decrement idx.
  - idx==0: go to IDLE, clear busy, pulse done.
- Predecessor of key {w0,w1,w2,w3} at round i:
  - p3 = w3^w2
  - p2 = w2^w1
  - p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon(i)
  - RotWord is a left byte rotate. Rcon(i) = {01,02,04,08,10,20,40,80,1b,36}[i-1] in the top byte. All arithmetic is 32-bit XOR.
- Backpressure: while rk_valid & !rk_ready, round_key and round_idx hold stable.
- start while busy=1 is ignored. last_key is sampled only on the accepting edge.
- Reset, including mid-sequence: state=IDLE; busy=0, rk_valid=0, done=0, round_key=0, round_idx=0. A sequence interrupted by reset is not resumed.

## Timing
- Start accepted at edge t → busy=1 and rk_valid=1 with idx 10 after edge t.
- Each accepted handshake updates to the next key after the same edge. Predecessor logic is a single combinational cycle: 4 S-boxes plus XORs.
- With rk_ready held high, 11 consecutive valid cycles: idx 10…0.
- done=1 for exactly the cycle after the idx-0 handshake; busy=0 and rk_valid=0 in that same cycle.
- A new start can be accepted in the done cycle (busy=0).

## Configuration
- AES_INV_KEY_EQINV_EN
  - Defined: for round_idx 1..9, round_key presents InvMixColumns(raw key), applied per 32-bit column, to feed the equivalent inverse cipher. Rounds 10 and 0 are output raw. The internal register always holds the raw key, and the transform is purely on the output path.
  - Undefined: round_key is always the raw key.

## Structure
- Shared package aes_pkg:
  - Rcon table (as a function indexed 1..10)
  - FSM state typedef
  - AES_NR=10 constant
  - GF(2^8) xtime/multiply helpers used by InvMixColumns
- One sub-module, aes_sbox: a combinational 8-bit forward S-box, instantiated 4 times for SubWord. It is reused by the encryption path.

## Test plan
- FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c:
  - Stimulus: last_key = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, rk_ready=1.
  - Expected: idx10 = last_key; idx9 = ac7766f3 19fadc21 28d12941 575c006e; idx1 = a0fafe17 88542cb1 23a33939 2a6c7605; idx0 = original key; done pulse at start+12.
- Backpressure:
  - Stimulus: rk_ready random, 30% high.
  - Expected: round_key/round_idx never change while valid&!ready; sequence identical to the previous test; exactly 11 handshakes, then one done.
- start while busy:
  - Stimulus: assert start with a different last_key at idx 5.
  - Expected: ignored; sequence continues to idx 0 with the original keys.
- Reset mid-sequence:
  - Stimulus: RST low at idx 6.
  - Expected: all outputs 0 asynchronously; after release, rk_valid stays 0 until a new start.
- Back-to-back:
  - Stimulus: start asserted in the done cycle.
  - Expected: new sequence with idx 10 visible the next cycle.
- With AES_INV_KEY_EQINV_EN:
  - Stimulus: the FIPS vector.
  - Expected: idx10 and idx0 match raw; idx1..9 equal a reference-model InvMixColumns of the raw keys.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES definitions for the AES-128 key schedule and
//               cipher datapaths. Contains the round count, the key-schedule
//               FSM state type, the Rcon table, and the GF(2^8) helpers used
//               by InvMixColumns.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // Number of rounds for AES-128.
  localparam int AES_NR = 10;

  // Inverse key schedule controller states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Round constant byte for rounds 1..10. It occupies the top byte of the
  // 32-bit Rcon word. Out-of-range indices return 0.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply a byte by a 4-bit constant. This covers the InvMixColumns
  // coefficients 09, 0b, 0d and 0e.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? a  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  // InvMixColumns applied to one 32-bit column. The first row is in the
  // most significant byte.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
            gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
            gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
            gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_key_schedule_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_key_schedule_if
// Description : Bundles the load request and the round-key handshake of the
//               inverse key schedule.
//               start     - load request (key source -> schedule)
//               last_key  - round-10 key, word 0 = bits [0:31], MSB first
//               busy      - a sequence is in progress
//               rk_valid  - round_key/round_idx are valid
//               rk_ready  - consumer accepts the current key
//               round_key - current round key
//               round_idx - round number of round_key (10 down to 0)
//               done      - one-cycle pulse after the round-0 key is accepted
//               Modport slave is used by the schedule, and modport master is
//               used by the key source and consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_inv_key_schedule_if;
  logic         start;
  logic [0:127] last_key;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [0:127] round_key;
  logic [3:0]   round_idx;
  logic         done;

  modport master (
    output start, last_key, rk_ready,
    input  busy, rk_valid, round_key, round_idx, done
  );

  modport slave (
    input  start, last_key, rk_ready,
    output busy, rk_valid, round_key, round_idx, done
  );
endinterface
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational AES forward S-box, implemented as a lookup
//               table. The key schedule and the encryption path both use
//               this module.
//               i_byte - input byte
//               o_byte - SubBytes(i_byte)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
  input  wire logic [7:0] i_byte,
  output logic      [7:0] o_byte
);

  // Entry n is stored at bits [8n : 8n+7], so the table reads left to right
  // in standard FIPS-197 order.
  localparam logic [0:2047] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = c_SBOX[{i_byte, 3'b000} +: 8];

endmodule
`default_nettype wire

// File: rtl/aes_inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_key_schedule
// Description : Iterative AES-128 inverse key schedule. It loads the round-10
//               key and regenerates round keys 10..0 one per handshake. Only
//               the current key is held, and each accepted handshake replaces
//               it with its predecessor.
//               CLK  - clock, rising edge
//               RST  - asynchronous active-low reset
//               kif  - aes_inv_key_schedule_if.slave (start/last_key in;
//                      busy, rk_valid/rk_ready handshake, round_key,
//                      round_idx, done)
//               Optional build macro AES_INV_KEY_EQINV_EN: when defined,
//               rounds 1..9 present InvMixColumns(raw key) for the
//               equivalent inverse cipher. Rounds 10 and 0 stay raw.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_key_schedule
  import aes_pkg::*;
(
  input wire logic               CLK,
  input wire logic               RST,
  aes_inv_key_schedule_if.slave  kif
);

  state_t       r_state;
  logic [0:127] r_key;
  logic [3:0]   r_idx;
  logic         r_busy;
  logic         r_valid;
  logic         r_done;

  // -------------------------------------------------------------------------
  // Predecessor key: undo one forward expansion step at round r_idx.
  // -------------------------------------------------------------------------
  logic [31:0]  w_w0;
  logic [31:0]  w_w1;
  logic [31:0]  w_w2;
  logic [31:0]  w_w3;
  logic [31:0]  w_p0;
  logic [31:0]  w_p1;
  logic [31:0]  w_p2;
  logic [31:0]  w_p3;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [0:127] w_pred;

  assign w_w0 = r_key[0:31];
  assign w_w1 = r_key[32:63];
  assign w_w2 = r_key[64:95];
  assign w_w3 = r_key[96:127];

  assign w_p3 = w_w3 ^ w_w2;
  assign w_p2 = w_w2 ^ w_w1;
  assign w_p1 = w_w1 ^ w_w0;

  // p3 is the last word of the previous round key. It feeds the g()
  // function that produced w0 in the forward direction.
  assign w_rot = {w_p3[23:0], w_p3[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_rot[8*gi +: 8]),
      .o_byte (w_sub[8*gi +: 8])
    );
  end

  assign w_p0   = w_w0 ^ w_sub ^ {rcon(r_idx), 24'h000000};
  assign w_pred = {w_p0, w_p1, w_p2, w_p3};

  // -------------------------------------------------------------------------
  // Controller
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_key   <= '0;
      r_idx   <= 4'd0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (kif.start) begin
            r_key   <= kif.last_key;
            r_idx   <= 4'(AES_NR);
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (kif.rk_ready) begin
            if (r_idx != 4'd0) begin
              r_key <= w_pred;
              r_idx <= r_idx - 4'd1;
            end else begin
              r_busy  <= 1'b0;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign kif.busy      = r_busy;
  assign kif.rk_valid  = r_valid;
  assign kif.round_idx = r_idx;
  assign kif.done      = r_done;

  // -------------------------------------------------------------------------
  // Output key path. The register always holds the raw key, and the
  // equivalent-inverse-cipher transform is applied only on the way out.
  // -------------------------------------------------------------------------
`ifdef AES_INV_KEY_EQINV_EN
  logic [0:127] w_imc_key;
  logic         w_use_imc;

  assign w_imc_key = {inv_mix_column(r_key[0:31]),
                      inv_mix_column(r_key[32:63]),
                      inv_mix_column(r_key[64:95]),
                      inv_mix_column(r_key[96:127])};
  assign w_use_imc = (r_idx != 4'd0) && (r_idx != 4'(AES_NR));
  assign kif.round_key = w_use_imc ? w_imc_key : r_key;
`else
  assign kif.round_key = r_key;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_inv_key_schedule
// Description : Self-checking bench for aes_inv_key_schedule. Expected round
//               keys come from the FIPS-197 AES-128 expansion of key
//               2b7e1516 28aed2a6 abf71588 09cf4f3c. They are queued when a
//               start is driven and compared on each handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_key_schedule;

  logic CLK;
  logic RST;

  aes_inv_key_schedule_if kif ();

  aes_inv_key_schedule dut (
    .CLK (CLK),
    .RST (RST),
    .kif (kif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]   idx;
    logic [0:127] key;
  } exp_t;

  exp_t         sb_q[$];
  logic [0:127] c_rk[0:10];
  int           n_checks;
  int           n_errors;
  int           hs_count;
  int           done_count;
  bit           r_held;
  logic [0:127] r_held_key;
  logic [3:0]   r_held_idx;

  task automatic check_value(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [0:127] expect_key(input int idx, input logic [0:127] raw);
    logic [0:127] r;
    r = raw;
`ifdef AES_INV_KEY_EQINV_EN
    if (idx >= 1 && idx <= 9) begin
      for (int c = 0; c < 4; c++) begin
        logic [7:0] a[4];
        for (int j = 0; j < 4; j++) a[j] = raw[32*c + 8*j +: 8];
        r[32*c      +: 8] = tb_gmul(a[0], 8'h0e) ^ tb_gmul(a[1], 8'h0b) ^ tb_gmul(a[2], 8'h0d) ^ tb_gmul(a[3], 8'h09);
        r[32*c + 8  +: 8] = tb_gmul(a[0], 8'h09) ^ tb_gmul(a[1], 8'h0e) ^ tb_gmul(a[2], 8'h0b) ^ tb_gmul(a[3], 8'h0d);
        r[32*c + 16 +: 8] = tb_gmul(a[0], 8'h0d) ^ tb_gmul(a[1], 8'h09) ^ tb_gmul(a[2], 8'h0e) ^ tb_gmul(a[3], 8'h0b);
        r[32*c + 24 +: 8] = tb_gmul(a[0], 8'h0b) ^ tb_gmul(a[1], 8'h0d) ^ tb_gmul(a[2], 8'h09) ^ tb_gmul(a[3], 8'h0e);
      end
    end
`else
    if (idx < 0) r = '0;
`endif
    return r;
  endfunction

  // Drive a start of the FIPS sequence and queue its 11 expected keys.
  task automatic drive_start();
    kif.start    = 1'b1;
    kif.last_key = c_rk[10];
    for (int i = 10; i >= 0; i--) begin
      exp_t e;
      e.idx = 4'(i);
      e.key = expect_key(i, c_rk[i]);
      sb_q.push_back(e);
    end
  endtask

  // Run until done. mode 0: ready high; 1: ready random 30%;
  // 2: a foreign start at idx 5; 3: reset at idx 6 (returns early).
  task automatic run_seq(input int mode, output int cycles);
    bit injected;
    bit finished;
    injected = 1'b0;
    finished = 1'b0;
    cycles   = 0;
    for (int n = 0; n < 400 && !finished; n++) begin
      @(posedge CLK);
      #1;
      cycles++;
      kif.start    = 1'b0;
      kif.rk_ready = (mode == 1) ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (mode == 2 && !injected && kif.rk_valid && kif.round_idx == 4'd5) begin
        kif.start    = 1'b1;
        kif.last_key = 128'h00112233445566778899aabbccddeeff;
        injected     = 1'b1;
      end
      if (mode == 3 && kif.rk_valid && kif.round_idx == 4'd6) begin
        #2;
        RST = 1'b0;
        #1;
        check_value("rst_busy",  128'(kif.busy),      128'd0);
        check_value("rst_valid", 128'(kif.rk_valid),  128'd0);
        check_value("rst_done",  128'(kif.done),      128'd0);
        check_value("rst_key",   128'(kif.round_key), 128'd0);
        check_value("rst_idx",   128'(kif.round_idx), 128'd0);
        sb_q.delete();
        finished = 1'b1;
      end else if (kif.done) begin
        finished = 1'b1;
      end
    end
    check_value("seq_finished", 128'(finished), 128'd1);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (RST && kif.rk_valid) begin
      if (r_held) begin
        check_value("hold_key", 128'(kif.round_key), 128'(r_held_key));
        check_value("hold_idx", 128'(kif.round_idx), 128'(r_held_idx));
      end
      r_held     = !kif.rk_ready;
      r_held_key = kif.round_key;
      r_held_idx = kif.round_idx;
      if (kif.rk_ready) begin
        hs_count++;
        check_value("sb_nonempty", 128'(sb_q.size() != 0), 128'd1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check_value("rk_idx", 128'(kif.round_idx), 128'(e.idx));
          check_value("rk_key", 128'(kif.round_key), 128'(e.key));
        end
      end
    end else begin
      r_held = 1'b0;
    end
    if (RST && kif.done) begin
      done_count++;
      check_value("done_busy",  128'(kif.busy),     128'd0);
      check_value("done_valid", 128'(kif.rk_valid), 128'd0);
    end
  end

  initial begin
    int cyc;
    c_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    c_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    c_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    c_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    c_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    c_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    c_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    c_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    c_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    c_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    c_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    n_checks = 0;
    n_errors = 0;
    r_held   = 1'b0;
    kif.start    = 1'b0;
    kif.last_key = '0;
    kif.rk_ready = 1'b0;
    RST = 1'b0;
    #12;
    check_value("init_busy",  128'(kif.busy),      128'd0);
    check_value("init_valid", 128'(kif.rk_valid),  128'd0);
    check_value("init_done",  128'(kif.done),      128'd0);
    check_value("init_key",   128'(kif.round_key), 128'd0);
    check_value("init_idx",   128'(kif.round_idx), 128'd0);
    @(negedge CLK);
    RST = 1'b1;

    // FIPS vector, ready held high.
    @(posedge CLK); #1;
    hs_count = 0; done_count = 0;
    kif.rk_ready = 1'b1;
    drive_start();
    run_seq(0, cyc);
    check_value("t1_done_latency", 128'(cyc), 128'd12);
    check_value("t1_handshakes",   128'(hs_count), 128'd11);
    check_value("t1_sb_empty",     128'(sb_q.size()), 128'd0);
    @(posedge CLK); #1;
    check_value("t1_done_pulse", 128'(kif.done), 128'd0);
    check_value("t1_done_count", 128'(done_count), 128'd1);

    // Random backpressure.
    hs_count = 0; done_count = 0;
    drive_start();
    run_seq(1, cyc);
    check_value("t2_handshakes", 128'(hs_count), 128'd11);
    check_value("t2_sb_empty",   128'(sb_q.size()), 128'd0);
    @(posedge CLK); #1;
    check_value("t2_done_count", 128'(done_count), 128'd1);

    // Start while busy is ignored.
    hs_count = 0; done_count = 0;
    kif.rk_ready = 1'b1;
    drive_start();
    run_seq(2, cyc);
    check_value("t3_handshakes", 128'(hs_count), 128'd11);
    check_value("t3_sb_empty",   128'(sb_q.size()), 128'd0);

    // Reset in the middle of a sequence.
    @(posedge CLK); #1;
    drive_start();
    run_seq(3, cyc);
    @(negedge CLK);
    RST = 1'b1;
    kif.start = 1'b0;
    repeat (4) begin
      @(posedge CLK); #1;
      check_value("t4_valid_after_rst", 128'(kif.rk_valid), 128'd0);
      check_value("t4_busy_after_rst",  128'(kif.busy),     128'd0);
    end

    // Back-to-back: restart in the done cycle.
    hs_count = 0; done_count = 0;
    drive_start();
    run_seq(0, cyc);
    check_value("t5_first_done", 128'(kif.done), 128'd1);
    drive_start();
    @(posedge CLK); #1;
    kif.start = 1'b0;
    check_value("t5_valid", 128'(kif.rk_valid), 128'd1);
    check_value("t5_idx",   128'(kif.round_idx), 128'd10);
    run_seq(0, cyc);
    check_value("t5_handshakes", 128'(hs_count), 128'd22);
    check_value("t5_sb_empty",   128'(sb_q.size()), 128'd0);
    @(posedge CLK); #1;
    check_value("t5_done_count", 128'(done_count), 128'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
